aq_djpeg_ycbcr2rgb: RTL
=======================

// Module: aq_djpeg_ycbcr2rgb
// PURPOSE
//  Downstream consumer of the YCbCr MCU buffer. Reads one 16x16 MCU (256 samples) per buffered bank.
//  Converts each sample to 8-bit RGB (JFIF / BT.601 full range) and presents the pixels on a valid/ready stream.
//  Drives the buffer's read address/strobe. Releases the bank by reading address 255.
// PARAMETERS
//  FIFO_DEPTH  8  output FIFO entries, power of 2, >=4. 8 gives 1 pixel/clk with ready held high.
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active-high
//  DataInit     in   1  synchronous flush: pipeline, FIFO and FSM to idle; address to 0
//  JpegComp     in   3  1 = grayscale (Cb, Cr forced to 0); 3 = colour
//  DataInEnable in   1  buffer holds an unread MCU (buffer's DataOutEnable)
//  DataInAddress out 8  sample index 0..255 presented to the buffer
//  DataInRead   out  1  read strobe; address 255 with strobe advances the buffer bank
//  DataInY      in   9  signed Y minus 128, valid 1 clk after strobe
//  DataInCb     in   9  signed Cb minus 128, valid 1 clk after strobe
//  DataInCr     in   9  signed Cr minus 128, valid 1 clk after strobe
//  OutEnable    out  1  pixel valid
//  OutReady     in   1  sink accepts; a transfer occurs when OutEnable & OutReady
//  OutRed       out  8  red
//  OutGreen     out  8  green
//  OutBlue      out  8  blue
//  OutIndex     out  8  sample index (DataInAddress of this pixel)
//  OutLast      out  1  OutIndex==255 (last pixel of MCU)
// BEHAVIOUR
//  Reset / DataInit values:
//   - All outputs 0; FSM S_IDLE; FIFO empty; in-flight count 0.
//   - DataInit has priority over every other event.
//  FSM:
//   - S_IDLE->S_READ when DataInEnable=1. Address starts at 0.
//   - S_READ: DataInRead=1 iff (fifo_count + inflight) < FIFO_DEPTH.
//     The same-cycle pop is not credited. The address increments on each strobe.
//   - The strobe at address 255 -> S_DRAIN, and the address wraps to 0.
//   - S_DRAIN->S_IDLE when inflight==0. This guarantees at least 1 clk for the buffer's bank/enable update.
//   - No read is issued in S_IDLE or S_DRAIN.
//  Pipeline (strobe in cycle t):
//   - t+1: buffer data valid; captured into stage 1 with its index.
//   - t+2: products registered (signed 9x10):
//       pR = 359*Cr
//       pG = -88*Cb - 183*Cr
//       pB = 454*Cb
//   - t+3: sums/clamp registered and written to the FIFO, with s = Y*256 + 32768 + 128:
//       R = clamp(s + pR)
//       G = clamp(s + pG)
//       B = clamp(s + pB)
//     clamp = arithmetic >>>8, then saturate to 0..255.
//   - Sums carry 21-bit signed width; no intermediate overflow.
//   - OutEnable from the FIFO head: first pixel valid at t+4 at the earliest.
//  Ordering and throughput:
//   - Pixels leave in strict index order 0..255. No drop or duplication under any OutReady pattern.
//   - inflight: +1 on strobe, -1 on FIFO write; range 0..3.
//   - FIFO full is never reached with a pending write (credit rule). Overflow is a design error; assert in sim.
//   - Pop on empty is ignored.
//   - With OutReady held high: 256 pixels in 256 consecutive clks after the first valid.
//  Stream hold:
//   - Output data is stable while OutEnable=1 & OutReady=0.
//  Back-to-back MCUs:
//   - If DataInEnable is still 1 in S_IDLE, the next MCU starts immediately.
//   - Pixels of successive MCUs never interleave.
//  Reset mid-MCU:
//   - Partially read bank is not released. The upstream buffer is flushed by the same DataInit/reset.
// TESTING
//  - Y=0,Cb=0,Cr=0 -> RGB 128,128,128. Y=127 -> 255,255,255. Y=-128 -> 0,0,0.
//  - Y=0,Cb=0,Cr=127 -> R=255 (sat from 306), G=37, B=128.
//    Y=0,Cb=-128,Cr=0 -> R=128, G=172, B=0.
//  - JpegComp=1, Y=50,Cb=100,Cr=-100 -> 178,178,178 (chroma ignored).
//  - One MCU, OutReady=1: first strobe at t -> OutEnable at t+4.
//    256 pixels, indices 0..255 contiguous. OutLast only on 255. Single strobe at address 255.
//  - OutReady low 20 clks mid-MCU -> OutEnable high, data stable. FIFO holds <=8. Strobes stop.
//    Resume -> no loss or duplicate; index sequence intact.
//  - DataInit (or rst) at pixel 100 -> outputs 0 next clk, FIFO empty.
//    New MCU after release -> starts at index 0.

Source files
------------

// File: rtl/aq_djpeg_ycbcr2rgb.sv
// YCbCr MCU buffer reader: BT.601 full-range colour conversion
// feeding a credit-controlled output FIFO with a valid/ready stream.
module aq_djpeg_ycbcr2rgb #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DataInit,
    input  logic [2:0]        JpegComp,
    input  logic              DataInEnable,
    output logic [7:0]        DataInAddress,
    output logic              DataInRead,
    input  logic signed [8:0] DataInY,
    input  logic signed [8:0] DataInCb,
    input  logic signed [8:0] DataInCr,
    output logic              OutEnable,
    input  logic              OutReady,
    output logic [7:0]        OutRed,
    output logic [7:0]        OutGreen,
    output logic [7:0]        OutBlue,
    output logic [7:0]        OutIndex,
    output logic              OutLast
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] idx;
    } px_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [AW:0] count_q, count_d;
    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    logic        v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic        rd, push, pop, credit_ok;

    logic [7:0]         idx0_q, idx1_q, idx2_q;
    logic signed [8:0]  y1_q, cb1_q, cr1_q, y2_q;
    logic signed [20:0] pr2_q, pg2_q, pb2_q;
    logic signed [20:0] s_w;
    px_t                mem_q [FIFO_DEPTH];
    px_t                wr_px, head;

    function automatic logic [7:0] clamp8(input logic signed [20:0] v);
        logic signed [20:0] t;
        t = v >>> 8;
        if (t[20]) return 8'd0;
        if (t > 21'sd255) return 8'hFF;
        return t[7:0];
    endfunction

    assign push      = v2_q;
    assign OutEnable = (count_q != '0);
    assign pop       = OutEnable & OutReady;
    // Credit ignores the same-cycle pop so the FIFO can never overflow.
    assign credit_ok = (int'(count_q) + int'(inflight_q)) < FIFO_DEPTH;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd         = 1'b0;
        inflight_d = inflight_q;
        count_d    = count_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        unique case (state_q)
            S_IDLE:  if (DataInEnable) state_d = S_READ;
            S_READ: begin
                rd = credit_ok & ~DataInit;
                if (rd) begin
                    addr_d = addr_q + 8'd1;
                    if (addr_q == 8'hFF) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (inflight_q == 2'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        case ({rd, push})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        if (push) wp_d = wp_q + ONE;
        if (pop) rp_d = rp_q + ONE;
        v0_d = rd;
        v1_d = v0_q;
        v2_d = v1_q;
        if (DataInit) begin
            state_d    = S_IDLE;
            addr_d     = 8'd0;
            inflight_d = 2'd0;
            count_d    = '0;
            wp_d       = '0;
            rp_d       = '0;
            v0_d       = 1'b0;
            v1_d       = 1'b0;
            v2_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 8'd0;
            inflight_q <= 2'd0;
            count_q    <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
        end
    end

    // Datapath carries no reset; validity travels in v0..v2.
    always_ff @(posedge clk) begin
        idx0_q <= addr_q;
        idx1_q <= idx0_q;
        y1_q   <= DataInY;
        cb1_q  <= (JpegComp == 3'd1) ? 9'sd0 : DataInCb;
        cr1_q  <= (JpegComp == 3'd1) ? 9'sd0 : DataInCr;
        idx2_q <= idx1_q;
        y2_q   <= y1_q;
        pr2_q  <= 21'(cr1_q) * 21'sd359;
        pg2_q  <= -(21'(cb1_q) * 21'sd88) - 21'(cr1_q) * 21'sd183;
        pb2_q  <= 21'(cb1_q) * 21'sd454;
        if (push && !DataInit) mem_q[wp_q[AW-1:0]] <= wr_px;
    end

    always_comb begin
        s_w       = (21'(y2_q) <<< 8) + 21'sd32896;
        wr_px.r   = clamp8(s_w + pr2_q);
        wr_px.g   = clamp8(s_w + pg2_q);
        wr_px.b   = clamp8(s_w + pb2_q);
        wr_px.idx = idx2_q;
    end

    assign head          = mem_q[rp_q[AW-1:0]];
    assign OutRed        = OutEnable ? head.r : 8'd0;
    assign OutGreen      = OutEnable ? head.g : 8'd0;
    assign OutBlue       = OutEnable ? head.b : 8'd0;
    assign OutIndex      = OutEnable ? head.idx : 8'd0;
    assign OutLast       = OutEnable && (head.idx == 8'hFF);
    assign DataInAddress = addr_q;
    assign DataInRead    = rd;

    always_ff @(posedge clk) begin
        if (!rst && !DataInit && push)
            assert (count_q != (AW + 1)'(FIFO_DEPTH))
            else $error("output fifo overflow");
    end
endmodule
